amb_yurut_denetleyici: RTL and testbench
========================================

// Module: amb_yurut_denetleyici
// PURPOSE
//  Execute-stage sequencer placed between issue/decode and the amb ALU, with writeback downstream.
//  Takes one ALU micro-op per valid/ready handshake and latches its operands.
//  Holds the operands and the op code stable on the amb port until amb signals result-valid.
//  Registers the result and compare flags and offers them to writeback through a second valid/ready handshake.
//  Handles single-cycle ops and multi-cycle ops (MUL*, DIV*, REM*, HMDST, CNTZ, CNTP) uniformly.
// PARAMETERS
//  VERI_BIT     32   data width; taken from the shared constants header.
//  UOP_AMB_BIT  5    amb micro-op code width; taken from the shared micro-op header.
//  HEDEF_BIT    5    destination register index width.
//  MAKS_GECIKME 64   watchdog limit, in cycles spent in MESGUL, before hata_o is raised.
// PORTS
//  clk_i              in   1            clock
//  rst_i              in   1            synchronous, active-high reset
//  temizle_i          in   1            pipeline flush; aborts any in-flight op
//  giris_gecerli_i    in   1            upstream op valid
//  giris_hazir_o      out  1            this block can accept an op
//  giris_kod_i        in   UOP_AMB_BIT  amb micro-op code
//  giris_islec1_i     in   VERI_BIT     operand 1
//  giris_islec2_i     in   VERI_BIT     operand 2
//  giris_hedef_i      in   HEDEF_BIT    destination register index
//  amb_kod_o          out  UOP_AMB_BIT  to amb islem_kod_i
//  amb_kod_gecerli_o  out  1            to amb islem_kod_gecerli_i
//  amb_islec1_o       out  VERI_BIT     to amb islem_islec1_i
//  amb_islec2_o       out  VERI_BIT     to amb islem_islec2_i
//  amb_sonuc_i        in   VERI_BIT     from amb islem_sonuc_o
//  amb_gecerli_i      in   1            from amb islem_gecerli_o
//  amb_bayrak_i       in   3            from amb {esittir, kucuktur, kucuktur_isaretsiz}
//  cikis_gecerli_o    out  1            result valid toward writeback
//  cikis_hazir_i      in   1            writeback accepts the result
//  cikis_sonuc_o      out  VERI_BIT     registered result
//  cikis_bayrak_o     out  3            registered flags, same order as amb_bayrak_i
//  cikis_hedef_o      out  HEDEF_BIT    registered destination index
//  hata_o             out  1            sticky watchdog error
// BEHAVIOUR
//  States: BOS (empty), MESGUL (amb working), DOLU (result held). Reset enters BOS.
//  Reset values: all outputs 0; the operand, result and counter registers are 0.
//  Upstream acceptance
//   - giris_hazir_o = (BOS) | (DOLU & cikis_hazir_i).
//   - An op is accepted when giris_gecerli_i & giris_hazir_o. Acceptance latches the code, operands and hedef.
//   - On acceptance the state goes to MESGUL in the next cycle.
//  MESGUL
//   - amb_kod_gecerli_o = 1; amb_kod_o and amb_islec*_o come from the latched registers.
//   - On amb_gecerli_i, amb_sonuc_i, amb_bayrak_i and the hedef are captured and the state goes to DOLU.
//   - A single-cycle op takes exactly one MESGUL cycle.
//  Outside MESGUL
//   - amb_kod_gecerli_o = 0. This clears the amb internal counter and accumulator between ops.
//   - amb_kod_o and amb_islec*_o keep their last latched values; they are don't-care.
//  Latency
//   - An op accepted in cycle N is presented to amb in cycle N+1. For ADD, cikis_gecerli_o is 1 in cycle N+2.
//   - Multi-cycle ops take N+1+k, where k is the number of MESGUL cycles.
//  Output side
//   - cikis_gecerli_o = 1 exactly in DOLU.
//   - The outputs stay stable while cikis_hazir_i = 0; backpressure stalls indefinitely.
//  DOLU transitions
//   - cikis_hazir_i with no new op: go to BOS.
//   - cikis_hazir_i with a simultaneous new acceptance: go straight to MESGUL, no bubble.
//  No combinational path from amb_* inputs to cikis_* outputs; all cikis_* outputs are registered.
//  temizle_i
//   - Highest priority after reset. Next state is BOS and any pending result is discarded.
//   - giris_hazir_o = 0 in the flush cycle; an op offered in that cycle is not accepted.
//   - amb_kod_gecerli_o = 0 in the cycle after the flush, so the amb counter returns to 0.
//  Watchdog
//   - A 7-bit counter increments in MESGUL, saturates at 127, and clears when MESGUL is entered.
//   - When the counter reaches MAKS_GECIKME, hata_o is set. hata_o clears only on rst_i; the FSM is unaffected.
//  Reset mid-operation: BOS on the next edge, all outputs 0, with the same amb counter clearing as a flush.
// STRUCTURE
//  - Use the existing micro-op header (UOP_AMB_*) and constants header (VERI_BIT, HIGH/LOW).
//  - Add the state encodings BOS/MESGUL/DOLU and the width MAKS_GECIKME to a shared execute-stage header.
//  - Single module: FSM, operand register, result register. No sub-module is warranted.
// TESTING
//  - ADD 5,7 accepted in cycle N, cikis_hazir_i=1 -> cikis_sonuc_o=12 valid in N+2; flags {0,1,1}.
//  - DIV 0x64,0 -> 0xFFFFFFFF in one MESGUL cycle. DIV 0x64,7 -> 14 after the amb divider latency.
//  - MUL 3,4 with cikis_hazir_i=0 for 10 cycles -> 12 held stable and giris_hazir_o=0 throughout;
//    releasing hazir while an op is offered -> the new op is accepted in the same cycle.
//  - Back-to-back ADD 1,1 ; SUB 9,4 ; XOR 0xF,0x3 with hazir=1 -> 2, 5, 0xC with one result every 2 cycles,
//    and hedef tags preserved in order.
//  - temizle_i during CNTP 0xFFFF -> no cikis_gecerli_o, amb_kod_gecerli_o low the next cycle,
//    and a following CNTP 0xF0 returns 4.
//  - Stub amb that never asserts gecerli -> hata_o=1 after 64 MESGUL cycles;
//    rst_i mid-op -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/amb_yurut_denetleyici_pkg.sv
// Shared execute-stage constants: data widths, amb micro-op codes, and the
// sequencer state encoding.
package amb_yurut_denetleyici_pkg;

  localparam int VERI_BIT     = 32;
  localparam int UOP_AMB_BIT  = 5;
  localparam int HEDEF_BIT    = 5;
  localparam int MAKS_GECIKME = 64;
  localparam int SAYAC_BIT    = 7;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_ADD   = 5'd0;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_SUB   = 5'd1;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_AND   = 5'd2;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_OR    = 5'd3;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_XOR   = 5'd4;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_MUL   = 5'd5;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_DIV   = 5'd6;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_REM   = 5'd7;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_CNTP  = 5'd8;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_CNTZ  = 5'd9;
  localparam logic [UOP_AMB_BIT-1:0] UOP_AMB_HMDST = 5'd10;

  typedef enum logic [1:0] {
    BOS    = 2'd0,
    MESGUL = 2'd1,
    DOLU   = 2'd2
  } durum_e;

  // Saturating increment for the watchdog counter.
  function automatic logic [SAYAC_BIT-1:0] sayac_artir(input logic [SAYAC_BIT-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/amb_yurut_denetleyici.sv
// Execute-stage sequencer: accepts one micro-op, holds it on the amb port
// until amb reports a result, then offers the registered result downstream.
module amb_yurut_denetleyici
  import amb_yurut_denetleyici_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   temizle_i,
  input  logic                   giris_gecerli_i,
  output logic                   giris_hazir_o,
  input  logic [UOP_AMB_BIT-1:0] giris_kod_i,
  input  logic [VERI_BIT-1:0]    giris_islec1_i,
  input  logic [VERI_BIT-1:0]    giris_islec2_i,
  input  logic [HEDEF_BIT-1:0]   giris_hedef_i,
  output logic [UOP_AMB_BIT-1:0] amb_kod_o,
  output logic                   amb_kod_gecerli_o,
  output logic [VERI_BIT-1:0]    amb_islec1_o,
  output logic [VERI_BIT-1:0]    amb_islec2_o,
  input  logic [VERI_BIT-1:0]    amb_sonuc_i,
  input  logic                   amb_gecerli_i,
  input  logic [2:0]             amb_bayrak_i,
  output logic                   cikis_gecerli_o,
  input  logic                   cikis_hazir_i,
  output logic [VERI_BIT-1:0]    cikis_sonuc_o,
  output logic [2:0]             cikis_bayrak_o,
  output logic [HEDEF_BIT-1:0]   cikis_hedef_o,
  output logic                   hata_o
);

  localparam logic [SAYAC_BIT-1:0] MAKS_SAYAC = SAYAC_BIT'(MAKS_GECIKME);

  durum_e                 durum_q, durum_d;
  logic                   kabul;
  logic [UOP_AMB_BIT-1:0] kod_q;
  logic [VERI_BIT-1:0]    islec1_q, islec2_q;
  logic [HEDEF_BIT-1:0]   hedef_q;
  logic [VERI_BIT-1:0]    sonuc_q;
  logic [2:0]             bayrak_q;
  logic [HEDEF_BIT-1:0]   cikis_hedef_q;
  logic                   yakala;
  logic [SAYAC_BIT-1:0]   sayac_q, sayac_d;
  logic                   hata_q, hata_d;

  assign kabul  = giris_gecerli_i & giris_hazir_o;
  assign yakala = (durum_q == MESGUL) & amb_gecerli_i & ~temizle_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) durum_q <= BOS;
    else       durum_q <= durum_d;
  end

  // Next state; a flush wins over everything except reset.
  always_comb begin
    durum_d = durum_q;
    if (temizle_i) begin
      durum_d = BOS;
    end else begin
      case (durum_q)
        BOS:     if (kabul) durum_d = MESGUL;
        MESGUL:  if (amb_gecerli_i) durum_d = DOLU;
        DOLU:    if (cikis_hazir_i) durum_d = kabul ? MESGUL : BOS;
        default: durum_d = BOS;
      endcase
    end
  end

  // Handshake outputs; held low while reset is asserted.
  always_comb begin
    giris_hazir_o     = LOW;
    amb_kod_gecerli_o = LOW;
    cikis_gecerli_o   = LOW;
    if (!rst_i) begin
      giris_hazir_o     = ~temizle_i &
                          ((durum_q == BOS) | ((durum_q == DOLU) & cikis_hazir_i));
      amb_kod_gecerli_o = (durum_q == MESGUL);
      cikis_gecerli_o   = (durum_q == DOLU);
    end
  end

  // Operand register: loaded only on acceptance so amb sees stable inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kod_q    <= '0;
      islec1_q <= '0;
      islec2_q <= '0;
      hedef_q  <= '0;
    end else if (kabul) begin
      kod_q    <= giris_kod_i;
      islec1_q <= giris_islec1_i;
      islec2_q <= giris_islec2_i;
      hedef_q  <= giris_hedef_i;
    end
  end

  // Result register: breaks any path from amb to the writeback outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sonuc_q       <= '0;
      bayrak_q      <= '0;
      cikis_hedef_q <= '0;
    end else if (yakala) begin
      sonuc_q       <= amb_sonuc_i;
      bayrak_q      <= amb_bayrak_i;
      cikis_hedef_q <= hedef_q;
    end
  end

  // Watchdog next state: counts MESGUL cycles, restarts on each new op.
  always_comb begin
    sayac_d = sayac_q;
    if (kabul)                  sayac_d = '0;
    else if (durum_q == MESGUL) sayac_d = sayac_artir(sayac_q);
    hata_d = hata_q | (sayac_d >= MAKS_SAYAC);
  end

  // Watchdog registers; the error flag is sticky until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sayac_q <= '0;
      hata_q  <= LOW;
    end else begin
      sayac_q <= sayac_d;
      hata_q  <= hata_d;
    end
  end

  assign amb_kod_o      = kod_q;
  assign amb_islec1_o   = islec1_q;
  assign amb_islec2_o   = islec2_q;
  assign cikis_sonuc_o  = sonuc_q;
  assign cikis_bayrak_o = bayrak_q;
  assign cikis_hedef_o  = cikis_hedef_q;
  assign hata_o         = hata_q;

endmodule

// File: tb/tb_amb_yurut_denetleyici.sv
// Bench for the execute-stage sequencer: a behavioural amb stub plus a
// result scoreboard fed from the ops offered upstream.
module tb_amb_yurut_denetleyici;
  import amb_yurut_denetleyici_pkg::*;

  logic        clk, rst, temizle, gv, hz;
  logic        giris_hazir, amb_kod_gecerli, amb_gecerli, cikis_gecerli, hata;
  logic [4:0]  kod, hd, amb_kod, cikis_hedef;
  logic [31:0] a, b, amb_islec1, amb_islec2, amb_sonuc, cikis_sonuc;
  logic [2:0]  amb_bayrak, cikis_bayrak;
  logic        stub_hang;
  int          acnt;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  typedef struct {
    logic [31:0] s;
    logic [2:0]  f;
    logic [4:0]  h;
  } exp_t;
  exp_t q[$];
  int   dlv_q[$];

  amb_yurut_denetleyici dut (
    .clk_i(clk), .rst_i(rst), .temizle_i(temizle),
    .giris_gecerli_i(gv), .giris_hazir_o(giris_hazir),
    .giris_kod_i(kod), .giris_islec1_i(a), .giris_islec2_i(b), .giris_hedef_i(hd),
    .amb_kod_o(amb_kod), .amb_kod_gecerli_o(amb_kod_gecerli),
    .amb_islec1_o(amb_islec1), .amb_islec2_o(amb_islec2),
    .amb_sonuc_i(amb_sonuc), .amb_gecerli_i(amb_gecerli), .amb_bayrak_i(amb_bayrak),
    .cikis_gecerli_o(cikis_gecerli), .cikis_hazir_i(hz),
    .cikis_sonuc_o(cikis_sonuc), .cikis_bayrak_o(cikis_bayrak),
    .cikis_hedef_o(cikis_hedef), .hata_o(hata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic straight from the op definitions.
  function automatic logic [31:0] ref_sonuc(input logic [4:0] k, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    case (k)
      UOP_AMB_ADD:  return x + y;
      UOP_AMB_SUB:  return x - y;
      UOP_AMB_AND:  return x & y;
      UOP_AMB_OR:   return x | y;
      UOP_AMB_XOR:  return x ^ y;
      UOP_AMB_MUL:  return x * y;
      UOP_AMB_DIV:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
      UOP_AMB_REM:  return (y == 0) ? x : x % y;
      UOP_AMB_CNTP: return 32'($countones(x));
      UOP_AMB_CNTZ: begin
        while (n < 32 && !x[n]) n++;
        return 32'(n);
      end
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic [2:0] ref_bayrak(input logic [31:0] x, input logic [31:0] y);
    return {x == y, $signed(x) < $signed(y), x < y};
  endfunction

  // Cycles the amb stub spends on an op (divide by zero finishes at once).
  function automatic int lat(input logic [4:0] k, input logic [31:0] y);
    case (k)
      UOP_AMB_MUL:               return 3;
      UOP_AMB_DIV, UOP_AMB_REM:  return (y == 0) ? 1 : 8;
      UOP_AMB_CNTP, UOP_AMB_CNTZ: return 4;
      default:                   return 1;
    endcase
  endfunction

  // amb stub: counts cycles with kod_gecerli high, clears when it drops.
  always @(posedge clk) begin
    if (!amb_kod_gecerli) acnt <= 0;
    else                  acnt <= acnt + 1;
  end
  assign amb_gecerli = amb_kod_gecerli && !stub_hang && (acnt == lat(amb_kod, amb_islec2) - 1);
  assign amb_sonuc   = ref_sonuc(amb_kod, amb_islec1, amb_islec2);
  assign amb_bayrak  = ref_bayrak(amb_islec1, amb_islec2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] k, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] h);
    gv = v; kod = k; a = x; b = y; hd = h;
  endtask

  // One clock: sample handshakes, update scoreboard, advance past the edge.
  task automatic cyc();
    exp_t e;
    #1;
    if (gv && giris_hazir) begin
      e.s = ref_sonuc(kod, a, b);
      e.f = ref_bayrak(a, b);
      e.h = hd;
      q.push_back(e);
    end
    if (cikis_gecerli && hz) begin
      dlv_q.push_back(cyc_n);
      if (q.size() == 0) chk("unexpected_result", 32'(cikis_gecerli), 32'd0);
      else begin
        e = q.pop_front();
        chk("sb_sonuc", cikis_sonuc, e.s);
        chk("sb_bayrak", 32'(cikis_bayrak), 32'(e.f));
        chk("sb_hedef", 32'(cikis_hedef), 32'(e.h));
      end
    end
    if (temizle || rst) q.delete();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Step until a result is offered; n is the number of cycles waited.
  task automatic wait_out(output int n);
    n = 0;
    forever begin
      #1;
      if (cikis_gecerli) break;
      if (n >= 200) begin
        chk("wait_out_timeout", 32'd0, 32'd1);
        break;
      end
      cyc();
      n++;
    end
  endtask

  initial begin
    int n, idx, sent;
    logic acc;
    logic [4:0] bk[3];
    logic [31:0] ba[3], bb[3];
    logic [4:0] rk[8];

    rst = 1; temizle = 0; hz = 0; stub_hang = 0;
    drive(0, 5'd0, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    cyc();
    // reset state
    #1;
    chk("rst_giris_hazir", 32'(giris_hazir), 32'd0);
    chk("rst_kod_gecerli", 32'(amb_kod_gecerli), 32'd0);
    chk("rst_cikis_gecerli", 32'(cikis_gecerli), 32'd0);
    chk("rst_cikis_sonuc", cikis_sonuc, 32'd0);
    chk("rst_hata", 32'(hata), 32'd0);
    chk("rst_amb_islec1", amb_islec1, 32'd0);
    rst = 0;
    #1 chk("idle_giris_hazir", 32'(giris_hazir), 32'd1);

    // ADD 5,7: presented in N+1, result valid in N+2
    hz = 1;
    drive(1, UOP_AMB_ADD, 32'd5, 32'd7, 5'd3);
    cyc();
    gv = 0;
    #1;
    chk("add_kod_gecerli_n1", 32'(amb_kod_gecerli), 32'd1);
    chk("add_amb_kod", 32'(amb_kod), 32'(UOP_AMB_ADD));
    chk("add_amb_islec1", amb_islec1, 32'd5);
    chk("add_amb_islec2", amb_islec2, 32'd7);
    chk("add_not_valid_n1", 32'(cikis_gecerli), 32'd0);
    cyc();
    #1;
    chk("add_valid_n2", 32'(cikis_gecerli), 32'd1);
    chk("add_sonuc", cikis_sonuc, 32'd12);
    chk("add_bayrak", 32'(cikis_bayrak), 32'b011);
    chk("add_kod_gecerli_low", 32'(amb_kod_gecerli), 32'd0);
    cyc();

    // DIV by zero finishes in one MESGUL cycle, DIV 0x64,7 after 8
    drive(1, UOP_AMB_DIV, 32'h64, 32'd0, 5'd4);
    cyc(); gv = 0;
    wait_out(n);
    chk("div0_mesgul_cycles", 32'(n), 32'd1);
    chk("div0_sonuc", cikis_sonuc, 32'hFFFF_FFFF);
    cyc();
    drive(1, UOP_AMB_DIV, 32'h64, 32'd7, 5'd5);
    cyc(); gv = 0;
    wait_out(n);
    chk("div7_mesgul_cycles", 32'(n), 32'd8);
    chk("div7_sonuc", cikis_sonuc, 32'd14);
    cyc();

    // MUL 3,4 under 10 cycles of backpressure, then release while an op waits
    hz = 0;
    drive(1, UOP_AMB_MUL, 32'd3, 32'd4, 5'd6);
    cyc(); gv = 0;
    wait_out(n);
    drive(1, UOP_AMB_ADD, 32'd1, 32'd2, 5'd9);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_valid", 32'(cikis_gecerli), 32'd1);
      chk("stall_sonuc", cikis_sonuc, 32'd12);
      chk("stall_hedef", 32'(cikis_hedef), 32'd6);
      chk("stall_giris_hazir", 32'(giris_hazir), 32'd0);
      cyc();
    end
    hz = 1;
    #1 chk("release_giris_hazir", 32'(giris_hazir), 32'd1);
    cyc(); gv = 0;
    #1;
    chk("no_bubble_kod_gecerli", 32'(amb_kod_gecerli), 32'd1);
    chk("no_bubble_islec2", amb_islec2, 32'd2);
    wait_out(n);
    cyc();

    // Back-to-back ADD, SUB, XOR with writeback always ready
    bk[0] = UOP_AMB_ADD; ba[0] = 32'd1;   bb[0] = 32'd1;
    bk[1] = UOP_AMB_SUB; ba[1] = 32'd9;   bb[1] = 32'd4;
    bk[2] = UOP_AMB_XOR; ba[2] = 32'hF;   bb[2] = 32'h3;
    dlv_q.delete();
    idx = 0;
    for (int c = 0; c < 40 && (idx < 3 || q.size() != 0); c++) begin
      if (idx < 3) drive(1, bk[idx], ba[idx], bb[idx], 5'(idx + 1));
      else gv = 0;
      #1 acc = gv && giris_hazir;
      cyc();
      if (acc) idx++;
    end
    gv = 0;
    chk("b2b_results", 32'(dlv_q.size()), 32'd3);
    if (dlv_q.size() == 3) begin
      chk("b2b_gap1", 32'(dlv_q[1] - dlv_q[0]), 32'd2);
      chk("b2b_gap2", 32'(dlv_q[2] - dlv_q[1]), 32'd2);
    end

    // Flush during CNTP 0xFFFF; the next CNTP 0xF0 must return 4
    drive(1, UOP_AMB_CNTP, 32'hFFFF, 32'd0, 5'd7);
    cyc();
    drive(1, UOP_AMB_CNTP, 32'hF0, 32'd0, 5'd8);
    temizle = 1;
    #1 chk("flush_giris_hazir", 32'(giris_hazir), 32'd0);
    cyc();
    temizle = 0;
    #1;
    chk("flush_kod_gecerli_next", 32'(amb_kod_gecerli), 32'd0);
    chk("flush_no_valid", 32'(cikis_gecerli), 32'd0);
    cyc(); gv = 0;
    wait_out(n);
    chk("cntp_after_flush", cikis_sonuc, 32'd4);
    chk("cntp_hedef", 32'(cikis_hedef), 32'd8);
    cyc();
    chk("flush_queue_empty", 32'(q.size()), 32'd0);

    // Random ops, random backpressure
    rk = '{UOP_AMB_ADD, UOP_AMB_SUB, UOP_AMB_AND, UOP_AMB_XOR,
           UOP_AMB_MUL, UOP_AMB_DIV, UOP_AMB_REM, UOP_AMB_CNTZ};
    sent = 0;
    for (int c = 0; c < 3000 && (sent < 40 || q.size() != 0); c++) begin
      if (!gv && sent < 40 && $urandom_range(0, 1) == 1)
        drive(1, rk[$urandom_range(0, 7)], $urandom,
              ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, 5'($urandom));
      hz = ($urandom_range(0, 3) != 0);
      #1 acc = gv && giris_hazir;
      cyc();
      if (acc) begin sent++; gv = 0; end
    end
    chk("rand_sent", 32'(sent), 32'd40);
    chk("rand_drained", 32'(q.size()), 32'd0);
    hz = 1;

    // Watchdog with a stub that never answers, then reset mid-op
    stub_hang = 1;
    drive(1, UOP_AMB_ADD, 32'd2, 32'd2, 5'd1);
    cyc(); gv = 0;
    for (int i = 0; i < 63; i++) cyc();
    #1 chk("wd_hata_63", 32'(hata), 32'd0);
    cyc();
    #1;
    chk("wd_hata_64", 32'(hata), 32'd1);
    chk("wd_still_busy", 32'(amb_kod_gecerli), 32'd1);
    cyc();
    #1 chk("wd_sticky", 32'(hata), 32'd1);
    rst = 1;
    cyc();
    #1;
    chk("midrst_kod_gecerli", 32'(amb_kod_gecerli), 32'd0);
    chk("midrst_hata", 32'(hata), 32'd0);
    chk("midrst_cikis_gecerli", 32'(cikis_gecerli), 32'd0);
    chk("midrst_amb_kod", 32'(amb_kod), 32'd0);
    chk("midrst_giris_hazir", 32'(giris_hazir), 32'd0);
    rst = 0; stub_hang = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
